// File: rtl/capture_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : capture_controller_if
// Description : Readout stream of the capture controller. The master
//               presents samples and the slave accepts them with a
//               valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface capture_controller_if #(
    parameter int SAMPLE_WIDTH = 8
);
    logic                    rd_valid;
    logic                    rd_ready;
    logic [SAMPLE_WIDTH-1:0] rd_data;
    logic                    rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface
`default_nettype wire

// File: rtl/capture_controller.sv
`default_nettype none
// ============================================================================
// Module      : capture_controller
// Description : Logic-analyser style capture. After arming, samples are
//               written into a circular buffer. Once the trigger arrives a
//               programmable number of post-trigger samples is kept. The
//               buffer is then streamed out, oldest sample first.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_controller #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH_LOG2   = 10
) (
    input  wire                     clock,
    input  wire                     resetn,
    input  wire                     start,
    input  wire                     abort,
    input  wire  [DEPTH_LOG2-1:0]   postTrigCount,
    input  wire                     valid,
    input  wire  [SAMPLE_WIDTH-1:0] dataIn,
    input  wire                     run,
    output logic                    arm,
    output logic                    armed,
    output logic                    triggered,
    output logic [DEPTH_LOG2-1:0]   trig_pos,
    output logic                    done,
    capture_controller_if.master    rd
);

    localparam int                  c_DEPTH_INT = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH     = (DEPTH_LOG2+1)'(c_DEPTH_INT);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_READOUT   = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [SAMPLE_WIDTH-1:0] r_mem [c_DEPTH_INT];
    logic [DEPTH_LOG2-1:0]   r_wptr;
    logic [DEPTH_LOG2:0]     r_fill;
    logic [DEPTH_LOG2-1:0]   r_ptc;
    logic [DEPTH_LOG2:0]     r_remain;
    logic [DEPTH_LOG2-1:0]   r_raddr;
    logic [DEPTH_LOG2:0]     r_left;      // samples not yet loaded into the output stage
    logic [DEPTH_LOG2-1:0]   r_trig_pos;
    logic                    r_rd_valid;
    logic                    r_rd_last;
    logic [SAMPLE_WIDTH-1:0] r_rd_data;
    logic                    r_done;

    logic                    w_write;
    logic                    w_accept_start;
    logic                    w_set_remain;
    logic                    w_enter_ro;
    logic                    w_last_xfer;
    logic [DEPTH_LOG2:0]     w_remain_init;
    logic [DEPTH_LOG2-1:0]   w_wptr_next;
    logic [DEPTH_LOG2:0]     w_fill_next;
    logic                    w_out_free;

    // A trigger cycle that carries a sample counts that sample as the trigger.
    assign w_remain_init = valid ? {1'b0, r_ptc} : ({1'b0, r_ptc} + 1'b1);
    assign w_wptr_next   = w_write ? (r_wptr + 1'b1) : r_wptr;
    assign w_fill_next   = (w_write && (r_fill != c_DEPTH)) ? (r_fill + 1'b1) : r_fill;
    assign w_out_free    = !r_rd_valid || rd.rd_ready;

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state and per-cycle control strobes; abort overrides everything.
    always_comb begin
        w_state_next   = r_state;
        w_write        = 1'b0;
        w_accept_start = 1'b0;
        w_set_remain   = 1'b0;
        w_enter_ro     = 1'b0;
        w_last_xfer    = 1'b0;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_next   = S_ARM;
                        w_accept_start = 1'b1;
                    end
                end
                S_ARM: w_state_next = S_WAIT_TRIG;
                S_WAIT_TRIG: begin
                    w_write = valid;
                    if (run) begin
                        w_set_remain = 1'b1;
                        if (w_remain_init == '0) begin
                            w_state_next = S_READOUT;
                            w_enter_ro   = 1'b1;
                        end else begin
                            w_state_next = S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (valid) begin
                        w_write = 1'b1;
                        if (r_remain == (DEPTH_LOG2+1)'(1)) begin
                            w_state_next = S_READOUT;
                            w_enter_ro   = 1'b1;
                        end
                    end
                end
                S_READOUT: begin
                    if (r_rd_valid && rd.rd_ready && r_rd_last) begin
                        w_state_next = S_IDLE;
                        w_last_xfer  = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Write pointer, fill level, latched post-trigger count and remaining count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr   <= '0;
            r_fill   <= '0;
            r_ptc    <= '0;
            r_remain <= '0;
        end else begin
            if (w_accept_start) begin
                r_ptc  <= postTrigCount;
                r_wptr <= '0;
                r_fill <= '0;
            end else begin
                r_wptr <= w_wptr_next;
                r_fill <= w_fill_next;
            end
            if (w_set_remain)
                r_remain <= w_remain_init;
            else if (w_write && (r_state == S_POST))
                r_remain <= r_remain - 1'b1;
        end
    end

    // Sample storage; contents survive reset.
    always_ff @(posedge clock) begin
        if (w_write) r_mem[r_wptr] <= dataIn;
    end

    // Readout: set up address and length on entry, then refill the output
    // register whenever it is empty or being consumed.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_raddr    <= '0;
            r_left     <= '0;
            r_trig_pos <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_xfer;
            if (abort) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
                r_left     <= '0;
            end else if (w_enter_ro) begin
                r_raddr    <= (w_fill_next == c_DEPTH) ? w_wptr_next : '0;
                r_left     <= w_fill_next;
                r_trig_pos <= DEPTH_LOG2'(w_fill_next - 1'b1 - {1'b0, r_ptc});
            end else if ((r_state == S_READOUT) && w_out_free) begin
                if (r_left != '0) begin
                    r_rd_data  <= r_mem[r_raddr];
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= (r_left == (DEPTH_LOG2+1)'(1));
                    r_raddr    <= r_raddr + 1'b1;
                    r_left     <= r_left - 1'b1;
                end else begin
                    r_rd_valid <= 1'b0;
                    r_rd_last  <= 1'b0;
                end
            end
        end
    end

    assign arm         = (r_state == S_ARM);
    assign armed       = (r_state == S_WAIT_TRIG);
    assign triggered   = (r_state == S_POST);
    assign trig_pos    = r_trig_pos;
    assign done        = r_done;
    assign rd.rd_valid = r_rd_valid;
    assign rd.rd_data  = r_rd_data;
    assign rd.rd_last  = r_rd_last;

endmodule
`default_nettype wire
